// File: rtl/alu_iq_pkg.sv
// Shared types and constants for the ALU issue queue: entry layout, issue packet layout, defaults.
package alu_iq_pkg;

  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned TAGW_DEF     = 6;
  localparam int unsigned DATAW        = 32;
  localparam int unsigned CTRLW        = 3;
  localparam int unsigned PKTW         = 67;
  localparam int unsigned PKT_SRC1_LSB = 0;
  localparam int unsigned PKT_SRC2_LSB = 32;
  localparam int unsigned PKT_CTRL_LSB = 64;

  typedef struct packed {
    logic                valid;
    logic [TAGW_DEF-1:0] rob_num;
    logic [CTRLW-1:0]    ctrl;
    logic [DATAW-1:0]    src1;
    logic [DATAW-1:0]    src2;
    logic                rdy1;
    logic                rdy2;
    logic [TAGW_DEF-1:0] tag1;
    logic [TAGW_DEF-1:0] tag2;
  } iq_entry_t;

  function automatic logic [PKTW-1:0] pack_pkt(input logic [CTRLW-1:0] ctrl,
                                               input logic [DATAW-1:0] src2,
                                               input logic [DATAW-1:0] src1);
    logic [PKTW-1:0] p;
    p = '0;
    p[PKT_CTRL_LSB +: CTRLW] = ctrl;
    p[PKT_SRC2_LSB +: DATAW] = src2;
    p[PKT_SRC1_LSB +: DATAW] = src1;
    return p;
  endfunction

endpackage

// File: rtl/alu_iq_select.sv
// Oldest-first priority picker: lowest set request bit wins; one-hot grant plus its index.
module alu_iq_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered ALU issue queue with CDB wakeup and a registered issue port.
// Define ALU_IQ_WAKEUP_FWD_EN to let a CDB wakeup issue in the same cycle (data forwarded).
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAGW  = TAGW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [TAGW-1:0]  disp_rob_num,
  input  logic [2:0]       disp_ctrl,
  input  logic [31:0]      disp_src1,
  input  logic [31:0]      disp_src2,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic [TAGW-1:0]  disp_src1_tag,
  input  logic [TAGW-1:0]  disp_src2_tag,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             alu_iss,
  output logic [66:0]      alu_data,
  output logic [TAGW-1:0]  alu_rob_num
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  iq_entry_t        q     [DEPTH];
  iq_entry_t        wk    [DEPTH];
  iq_entry_t        q_nxt [DEPTH];
  iq_entry_t        new_ent;
  iq_entry_t        iss_ent;
  logic [CNTW-1:0]  count, count_after, count_nxt;
  logic [DEPTH-1:0] req, grant;
  logic [IW-1:0]    sel_idx;
  logic             sel_any;
  logic             dispatch;
  logic             shift;

  assign disp_ready = (count < CNTW'(DEPTH));
  assign dispatch   = disp_valid && disp_ready && !flush;

  // Wakeup: only operands still waiting capture the broadcast.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wk[i] = q[i];
      if (cdb_valid && q[i].valid) begin
        if (!q[i].rdy1 && q[i].tag1 == cdb_tag) begin
          wk[i].rdy1 = 1'b1;
          wk[i].src1 = cdb_data;
        end
        if (!q[i].rdy2 && q[i].tag2 == cdb_tag) begin
          wk[i].rdy2 = 1'b1;
          wk[i].src2 = cdb_data;
        end
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.rob_num = disp_rob_num;
    new_ent.ctrl    = disp_ctrl;
    new_ent.src1    = disp_src1;
    new_ent.src2    = disp_src2;
    new_ent.rdy1    = disp_src1_rdy;
    new_ent.rdy2    = disp_src2_rdy;
    new_ent.tag1    = disp_src1_tag;
    new_ent.tag2    = disp_src2_tag;
    if (cdb_valid && !disp_src1_rdy && disp_src1_tag == cdb_tag) begin
      new_ent.rdy1 = 1'b1;
      new_ent.src1 = cdb_data;
    end
    if (cdb_valid && !disp_src2_rdy && disp_src2_tag == cdb_tag) begin
      new_ent.rdy2 = 1'b1;
      new_ent.src2 = cdb_data;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef ALU_IQ_WAKEUP_FWD_EN
      req[i] = wk[i].valid && wk[i].rdy1 && wk[i].rdy2;
`else
      req[i] = q[i].valid && q[i].rdy1 && q[i].rdy2;
`endif
    end
  end

  alu_iq_select #(.N(DEPTH), .IW(IW)) u_select (
    .req   (req),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

`ifdef ALU_IQ_WAKEUP_FWD_EN
  assign iss_ent = wk[sel_idx];
`else
  assign iss_ent = q[sel_idx];
`endif

  // Collapse: entries at or above the granted slot take their younger neighbour,
  // then a dispatch lands in the first slot free after the collapse.
  always_comb begin
    shift = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      shift = shift | grant[i];
      if (shift) begin
        if (i + 1 < DEPTH) q_nxt[i] = wk[i+1];
        else               q_nxt[i] = '0;
      end else begin
        q_nxt[i] = wk[i];
      end
    end
    count_after = count - CNTW'(sel_any);
    if (dispatch) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 32'(count_after)) q_nxt[i] = new_ent;
      end
    end
    count_nxt = count_after + CNTW'(dispatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= '{default: '0};
      count       <= '0;
      alu_iss     <= 1'b0;
      alu_data    <= '0;
      alu_rob_num <= '0;
    end else if (flush) begin
      q       <= '{default: '0};
      count   <= '0;
      alu_iss <= 1'b0;
    end else begin
      q       <= q_nxt;
      count   <= count_nxt;
      alu_iss <= sel_any;
      if (sel_any) begin
        alu_data    <= pack_pkt(iss_ent.ctrl, iss_ent.src2, iss_ent.src1);
        alu_rob_num <= iss_ent.rob_num;
      end
    end
  end

endmodule
